// File: rtl/vscale_ext_int_ctrl.sv
// vscale_ext_int_ctrl: external interrupt controller for the CSR file's
// external-interrupt vector. It synchronises raw request lines and applies
// per-source edge or level capture. It masks each source with ENABLE and
// tracks claim/complete through a small register port. It drives one
// registered interrupt level per source.
//
// Register port handshake: req_valid marks a one-cycle request that is
// always accepted (there is no ready signal and no backpressure). Exactly
// one cycle later resp_valid pulses for one cycle. In that cycle resp_rdata
// holds the read data (0 for writes) and resp_err flags an unmapped address.
// A synchronous reset in the request cycle discards the response.
//
// Register map (word offsets; address bits [1:0] ignored):
//   0x00 PENDING   read; write-1-to-clear for edge-mode sources
//   0x04 ENABLE    read/write
//   0x08 EDGE      read/write, 1 = rising-edge capture, 0 = level
//   0x0C CLAIM     read claims the lowest eligible source (id = index+1),
//                  write completes source id wdata[4:0]
//   0x10 INSERVICE read-only
module vscale_ext_int_ctrl #(
  parameter int N_SRC  = 24,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_raw,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [N_SRC-1:0]  ext_interrupts
);

  localparam int WORD_W = ADDR_W - 2;

  localparam logic [WORD_W-1:0] REG_PENDING   = WORD_W'(0);
  localparam logic [WORD_W-1:0] REG_ENABLE    = WORD_W'(1);
  localparam logic [WORD_W-1:0] REG_EDGE      = WORD_W'(2);
  localparam logic [WORD_W-1:0] REG_CLAIM     = WORD_W'(3);
  localparam logic [WORD_W-1:0] REG_INSERVICE = WORD_W'(4);

  // Synchroniser and edge detection
  logic [N_SRC-1:0] sync_s1;
  logic [N_SRC-1:0] sync_s2;
  logic [N_SRC-1:0] sync_prev;
  logic [N_SRC-1:0] rise;

  // Per-source state
  logic [N_SRC-1:0] edge_flop;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] edge_q;
  logic [N_SRC-1:0] in_service;

  // Derived per-source views
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] edge_next;
  logic [N_SRC-1:0] pend_clr;
  logic [N_SRC-1:0] claim_onehot;
  logic [N_SRC-1:0] complete_onehot;
  logic [4:0]       claim_id;

  // Request decode
  logic [WORD_W-1:0] req_word;
  logic [N_SRC-1:0]  wdata_src;
  logic              addr_mapped;
  logic              wr_pending;
  logic              wr_enable;
  logic              wr_edge;
  logic              rd_claim;
  logic              wr_claim;
  logic [31:0]       rd_data;

  // Address low bits and wdata bits above the source field carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{req_addr[1:0], req_wdata};

  assign req_word    = req_addr[ADDR_W-1:2];
  assign wdata_src   = req_wdata[N_SRC-1:0];
  assign addr_mapped = (req_word <= REG_INSERVICE);

  assign wr_pending = req_valid &  req_we & (req_word == REG_PENDING);
  assign wr_enable  = req_valid &  req_we & (req_word == REG_ENABLE);
  assign wr_edge    = req_valid &  req_we & (req_word == REG_EDGE);
  assign rd_claim   = req_valid & ~req_we & (req_word == REG_CLAIM);
  assign wr_claim   = req_valid &  req_we & (req_word == REG_CLAIM);

  // Two-flop synchroniser per line plus a delayed copy for rise detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_s1   <= '0;
      sync_s2   <= '0;
      sync_prev <= '0;
    end else begin
      sync_s1   <= irq_raw;
      sync_s2   <= sync_s1;
      sync_prev <= sync_s2;
    end
  end

  assign rise = sync_s2 & ~sync_prev;

  // Edge sources report the sticky flop and a rise in progress, so edge and
  // level sources share the same 3-cycle path to ext_interrupts. Level
  // sources report the synchronised line directly.
  assign pending  = (edge_q & (edge_flop | rise)) | (~edge_q & sync_s2);
  assign eligible = pending & enable_q & ~in_service;

  // Lowest eligible source wins the claim; 0 means nothing is eligible.
  always_comb begin
    claim_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        claim_id = 5'(i + 1);
      end
    end
  end

  // Decode a claim read and a complete write into per-source strobes.
  // Ids of 0 or above N_SRC match no source and are silently ignored.
  always_comb begin
    claim_onehot    = '0;
    complete_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_onehot[i]    = rd_claim & (claim_id == 5'(i + 1));
      complete_onehot[i] = wr_claim & (req_wdata[4:0] == 5'(i + 1));
    end
  end

  // Sticky-flop clear sources and the EDGE value that will hold next cycle.
  always_comb begin
    pend_clr  = claim_onehot;
    if (wr_pending) begin
      pend_clr = pend_clr | wdata_src;
    end
    edge_next = wr_edge ? wdata_src : edge_q;
  end

  // Edge-capture flops: a rise beats a same-cycle clear. A source that is
  // (or is becoming) level mode holds its flop at 0, which also discards
  // captured state when EDGE goes from 1 to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_flop <= '0;
    end else begin
      edge_flop <= edge_next & ((edge_flop & ~pend_clr) | rise);
    end
  end

  // ENABLE and EDGE configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
      edge_q   <= '0;
    end else begin
      if (wr_enable) begin
        enable_q <= wdata_src;
      end
      edge_q <= edge_next;
    end
  end

  // In-service tracking: a claim sets the claimed source and a complete
  // clears the named one. Both cannot happen in the same request.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_service <= '0;
    end else begin
      in_service <= (in_service | claim_onehot) & ~complete_onehot;
    end
  end

  // Registered interrupt levels towards the CSR file.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_interrupts <= '0;
    end else begin
      ext_interrupts <= eligible;
    end
  end

  // Read data mux; values reflect state before this request's updates.
  always_comb begin
    rd_data = '0;
    case (req_word)
      REG_PENDING:   rd_data[N_SRC-1:0] = pending;
      REG_ENABLE:    rd_data[N_SRC-1:0] = enable_q;
      REG_EDGE:      rd_data[N_SRC-1:0] = edge_q;
      REG_CLAIM:     rd_data[4:0]       = claim_id;
      REG_INSERVICE: rd_data[N_SRC-1:0] = in_service;
      default:       rd_data            = '0;
    endcase
  end

  // Response stage: one cycle after every request, reset discards it.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= req_valid;
      resp_rdata <= (req_valid & ~req_we & addr_mapped) ? rd_data : '0;
      resp_err   <= req_valid & ~addr_mapped;
    end
  end

endmodule

// File: tb/tb_vscale_ext_int_ctrl.sv
// Directed bench for vscale_ext_int_ctrl: bus responses are checked
// through an expected queue, interrupt levels through cycle-exact checks.
module tb_vscale_ext_int_ctrl;

  localparam int N = 24;

  localparam logic [7:0] A_PEND  = 8'h00;
  localparam logic [7:0] A_EN    = 8'h04;
  localparam logic [7:0] A_EDGE  = 8'h08;
  localparam logic [7:0] A_CLAIM = 8'h0C;
  localparam logic [7:0] A_INSV  = 8'h10;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          reset;
  logic [N-1:0]  irq_raw;
  logic          req_valid;
  logic          req_we;
  logic [7:0]    req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [N-1:0]  ext_interrupts;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vscale_ext_int_ctrl #(.N_SRC(N), .ADDR_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_raw        (irq_raw),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .ext_interrupts (ext_interrupts)
  );

  // ---------------- counters / scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [32:0] exp_q[$];   // {err, rdata}
  string       tag_q[$];
  logic        exp_rv = 1'b0;
  logic        mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor: resp_valid must follow each non-reset request by one
  // cycle; each response is compared with the oldest queued expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    string       t;
    if (mon_en) begin
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (resp_valid === 1'b1) begin
        chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          chk({t, "_rdata"}, resp_rdata, e[31:0]);
          chk({t, "_err"}, 32'(resp_err), 32'(e[32]));
        end
      end
    end
    exp_rv = (req_valid === 1'b1) && (reset === 1'b0);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input string tag, input logic we, input logic [7:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    tag_q.push_back(tag);
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wdata = '0;
  endtask

  task automatic wr(input string tag, input logic [7:0] addr, input logic [31:0] d);
    bus(tag, 1'b1, addr, d, 32'd0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    bus(tag, 1'b0, addr, 32'd0, exp, 1'b0);
  endtask

  // Check ext_interrupts in the current cycle, then advance one cycle.
  task automatic expect_ext(input string tag, input logic [N-1:0] exp);
    @(negedge clk);
    chk(tag, 32'(ext_interrupts), 32'(exp));
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset     = 1'b1;
    irq_raw   = '0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) step();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    step();
    expect_ext("rst_ext", '0);
    rd("rst_pend", A_PEND, 0);
    rd("rst_en", A_EN, 0);
    rd("rst_edge", A_EDGE, 0);
    rd("rst_claim", A_CLAIM, 0);
    rd("rst_insv", A_INSV, 0);

    // 1. Level source 0: 3-cycle latency both ways, PENDING tracks the line
    wr("t1_en", A_EN, 32'h1);
    irq_raw[0] = 1'b1;
    expect_ext("t1_rise_c0", 24'h0);
    expect_ext("t1_rise_c1", 24'h0);
    expect_ext("t1_rise_c2", 24'h0);
    expect_ext("t1_rise_c3", 24'h1);
    rd("t1_pend_hi", A_PEND, 32'h1);
    irq_raw[0] = 1'b0;
    expect_ext("t1_fall_c0", 24'h1);
    expect_ext("t1_fall_c1", 24'h1);
    expect_ext("t1_fall_c2", 24'h1);
    expect_ext("t1_fall_c3", 24'h0);
    rd("t1_pend_lo", A_PEND, 32'h0);
    wr("t1_en_off", A_EN, 32'h0);

    // 2. Edge capture on source 2
    wr("t2_edge", A_EDGE, 32'h4);
    wr("t2_en", A_EN, 32'h4);
    irq_raw[2] = 1'b1;
    expect_ext("t2_c0", 24'h0);
    irq_raw[2] = 1'b0;
    expect_ext("t2_c1", 24'h0);
    expect_ext("t2_c2", 24'h0);
    expect_ext("t2_c3", 24'h4);
    expect_ext("t2_c4_sticky", 24'h4);
    rd("t2_pend_sticky", A_PEND, 32'h4);
    // W1C in the same cycle as a new rise: the set wins
    irq_raw[2] = 1'b1;
    step();
    irq_raw[2] = 1'b0;
    step();
    wr("t2_w1c_race", A_PEND, 32'h4);
    rd("t2_pend_setwins", A_PEND, 32'h4);
    // Plain W1C clears
    wr("t2_w1c", A_PEND, 32'h4);
    rd("t2_pend_cleared", A_PEND, 32'h0);
    expect_ext("t2_ext_cleared", 24'h0);
    // EDGE 1 -> 0 discards captured state
    irq_raw[2] = 1'b1;
    step();
    irq_raw[2] = 1'b0;
    repeat (4) step();
    rd("t2_pend_again", A_PEND, 32'h4);
    wr("t2_edge_off", A_EDGE, 32'h0);
    wr("t2_edge_on", A_EDGE, 32'h4);
    rd("t2_pend_discard", A_PEND, 32'h0);
    wr("t2_en_off", A_EN, 32'h0);
    wr("t2_edge_clr", A_EDGE, 32'h0);

    // 3. Claim / complete with sources 3 and 5 (edge mode)
    wr("t3_edge", A_EDGE, 32'h28);
    wr("t3_en", A_EN, 32'h28);
    irq_raw = 24'h28;
    step();
    irq_raw = '0;
    step();
    step();
    expect_ext("t3_ext_both", 24'h28);
    rd("t3_claim4", A_CLAIM, 32'd4);
    rd("t3_insv8", A_INSV, 32'h8);
    expect_ext("t3_ext_src5", 24'h20);
    rd("t3_claim6", A_CLAIM, 32'd6);
    wr("t3_complete4", A_CLAIM, 32'd4);
    rd("t3_insv20", A_INSV, 32'h20);
    rd("t3_claim_none", A_CLAIM, 32'd0);
    rd("t3_pend_none", A_PEND, 32'h0);
    wr("t3_complete0", A_CLAIM, 32'd0);
    wr("t3_complete25", A_CLAIM, 32'd25);
    rd("t3_insv_kept", A_INSV, 32'h20);
    wr("t3_complete_idle", A_CLAIM, 32'd1);
    rd("t3_insv_noop", A_INSV, 32'h20);
    wr("t3_complete6", A_CLAIM, 32'd6);
    rd("t3_insv_empty", A_INSV, 32'h0);
    wr("t3_en_off", A_EN, 32'h0);
    wr("t3_edge_off", A_EDGE, 32'h0);

    // 4. Masking on level source 7
    irq_raw[7] = 1'b1;
    repeat (4) step();
    expect_ext("t4_masked", 24'h0);
    rd("t4_claim_masked", A_CLAIM, 32'd0);
    rd("t4_pend", A_PEND, 32'h80);
    wr("t4_en", A_EN, 32'h80);
    expect_ext("t4_w_plus1", 24'h0);
    expect_ext("t4_w_plus2", 24'h80);
    rd("t4_claim8", A_CLAIM, 32'd8);
    wr("t4_complete8", A_CLAIM, 32'd8);
    irq_raw[7] = 1'b0;
    wr("t4_en_off", A_EN, 32'h0);

    // 5. Bus edge cases
    bus("t5_rd_unmapped", 1'b0, 8'h14, 32'd0, 32'd0, 1'b1);
    bus("t5_rd_high", 1'b0, 8'hFC, 32'd0, 32'd0, 1'b1);
    wr("t5_en_ff", A_EN, 32'hFF);
    rd("t5_en_b2b", A_EN, 32'hFF);
    bus("t5_wr_unmapped", 1'b1, 8'h14, 32'd0, 32'd0, 1'b1);
    rd("t5_en_untouched", A_EN, 32'hFF);
    rd("t5_en_lowbits", 8'h06, 32'hFF);
    wr("t5_wr_insv", A_INSV, 32'hFFFF);
    rd("t5_insv_ro", A_INSV, 32'h0);
    wr("t5_en_all", A_EN, 32'hFFFF_FFFF);
    rd("t5_en_mask", A_EN, 32'h00FF_FFFF);
    wr("t5_edge_all", A_EDGE, 32'hFFFF_FFFF);
    rd("t5_edge_mask", A_EDGE, 32'h00FF_FFFF);
    wr("t5_edge_off", A_EDGE, 32'h0);
    wr("t5_en_off", A_EN, 32'h0);

    // 6. Reset mid-operation with a source in service and another pending
    wr("t6_edge", A_EDGE, 32'h1);
    wr("t6_en", A_EN, 32'h1);
    irq_raw[0] = 1'b1;
    step();
    irq_raw[0] = 1'b0;
    repeat (3) step();
    rd("t6_claim1", A_CLAIM, 32'd1);
    irq_raw[0] = 1'b1;
    step();
    irq_raw[0] = 1'b0;
    repeat (3) step();
    rd("t6_insv", A_INSV, 32'h1);
    rd("t6_pend", A_PEND, 32'h1);
    // Read issued in the same cycle reset asserts: no response may appear
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = A_CLAIM;
    reset     = 1'b1;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t6_resp_discard", 32'(resp_valid), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rdata_zero", resp_rdata, 32'd0);
    chk("t6_err_zero", 32'(resp_err), 32'd0);
    step();
    expect_ext("t6_ext_zero", 24'h0);
    rd("t6_pend_zero", A_PEND, 32'h0);
    rd("t6_en_zero", A_EN, 32'h0);
    rd("t6_edge_zero", A_EDGE, 32'h0);
    rd("t6_insv_zero", A_INSV, 32'h0);
    rd("t6_claim_zero", A_CLAIM, 32'd0);

    // Drain and report
    repeat (3) step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
